// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host instructions in a FIFO and feeds the controller
// one registered instruction per clock, inserting blanks after streaming ops (MAC / send weights).
module instr_issue_queue #(
  parameter  int DEPTH      = 16,
  parameter  int STREAM_LEN = 8,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      host_instr,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [63:0]      instruction,
  output logic [PTR_W:0]   q_count,
  output logic             busy
);

  // Handshake: a word transfers on a rising edge where host_valid && host_ready.
  // Opcode 00000 completes the handshake but is never stored.

  localparam int             CNT_W    = $clog2(STREAM_LEN + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [4:0]     OP_NONE  = 5'b00000;
  localparam logic [4:0]     OP_MAC   = 5'b00001;
  localparam logic [4:0]     OP_SEND  = 5'b00010;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic [63:0]      instr_nxt;
  logic [63:0]      head;
  logic             pop;
  logic             store;

  assign host_ready = rst_n && !flush && (q_count != FULL_CNT);
  assign store      = host_valid && host_ready && (host_instr[63:59] != OP_NONE);
  assign busy       = (q_count != '0) || (state == ST_HOLD);
  assign head       = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    instr_nxt = '0;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        if (!stall && (q_count != '0)) begin
          pop       = 1'b1;
          instr_nxt = head;
          if ((head[63:59] == OP_MAC) || (head[63:59] == OP_SEND)) begin
            state_nxt = ST_HOLD;
            hold_nxt  = CNT_W'(STREAM_LEN);
          end
        end
      end
      ST_HOLD: begin
        // The streaming op just issued owns the controller for STREAM_LEN blank cycles.
        hold_nxt = hold_cnt - CNT_W'(1);
        if (hold_cnt == CNT_W'(1)) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      instruction <= '0;
      state       <= ST_RUN;
      hold_cnt    <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      q_count     <= q_count + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
      instruction <= instr_nxt;
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  // Storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= host_instr;
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios plus random traffic, checked against a
// queue-based reference model and an expected-instruction scoreboard.
module tb_instr_issue_queue;

  localparam int DEPTH      = 16;
  localparam int STREAM_LEN = 8;
  localparam int PTR_W      = 4;

  logic             clk;
  logic             rst_n;
  logic [63:0]      host_instr;
  logic             host_valid;
  logic             host_ready;
  logic             stall;
  logic             flush;
  logic [63:0]      instruction;
  logic [PTR_W:0]   q_count;
  logic             busy;

  logic [63:0] exp_q[$];
  int          m_hold;
  bit          m_issue;
  int          n_checks;
  int          n_fail;

  instr_issue_queue #(.DEPTH(DEPTH), .STREAM_LEN(STREAM_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_instr (host_instr),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .stall      (stall),
    .flush      (flush),
    .instruction(instruction),
    .q_count    (q_count),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [4:0] op);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[63:59] = op;
    return r;
  endfunction

  function automatic logic [4:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 5'b00000;
      1:       return 5'b00001;
      2:       return 5'b00010;
      3:       return 5'b11111;
      default: return 5'($urandom_range(3, 30));
    endcase
  endfunction

  // ---------------- reference model ----------------
  // exp_q holds exactly what the queue should contain; the head is consumed by the monitor
  // once the model decides it was issued. m_hold counts blank cycles still owed after a
  // streaming op.
  always @(posedge clk) begin
    bit          m_ready;
    logic [4:0]  op;
    m_ready = rst_n && !flush && (exp_q.size() < DEPTH);
    chk(host_ready === m_ready, "host_ready", 64'(host_ready), 64'(m_ready));
    m_issue = 1'b0;
    if (!rst_n || flush) begin
      exp_q.delete();
      m_hold = 0;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
      end else if (!stall && exp_q.size() > 0) begin
        m_issue = 1'b1;
        op = exp_q[0][63:59];
        if (op == 5'b00001 || op == 5'b00010) m_hold = STREAM_LEN;
      end
      if (host_valid && m_ready && host_instr[63:59] != 5'b00000) exp_q.push_back(host_instr);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [63:0]    exp_w;
    logic [PTR_W:0] exp_cnt;
    #1;
    if (m_issue) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "sb_empty", instruction, 64'd0);
      end else begin
        exp_w = exp_q.pop_front();
        chk(instruction === exp_w, "issue", instruction, exp_w);
      end
    end else begin
      chk(instruction === 64'd0, "blank", instruction, 64'd0);
    end
    exp_cnt = (PTR_W+1)'(exp_q.size());
    chk(q_count === exp_cnt, "q_count", 64'(q_count), 64'(exp_cnt));
    chk(busy === (exp_q.size() != 0 || m_hold != 0), "busy", 64'(busy),
        64'(exp_q.size() != 0 || m_hold != 0));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [63:0] w, input bit st, input bit fl);
    @(negedge clk);
    host_valid = v;
    host_instr = w;
    stall      = st;
    flush      = fl;
  endtask

  task automatic push_word(input logic [63:0] w, input bit st);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      drive(1'b1, w, st, 1'b0);
      #1;
      if (host_ready === 1'b1) begin
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 300) begin
          chk(1'b0, "push_timeout", 64'(host_ready), 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit st);
    repeat (n) drive(1'b0, 64'd0, st, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] w17;
    n_checks   = 0;
    n_fail     = 0;
    m_hold     = 0;
    m_issue    = 1'b0;
    rst_n      = 1'b0;
    host_valid = 1'b1;
    host_instr = mk(5'b00100);
    stall      = 1'b0;
    flush      = 1'b0;

    // Reset held two cycles while the host offers a word.
    repeat (2) @(negedge clk);
    chk(host_ready === 1'b0, "reset_ready", 64'(host_ready), 64'd0);
    rst_n      = 1'b1;
    host_valid = 1'b0;

    // Back-to-back pushes, no stall.
    push_word(mk(5'b00100), 1'b0);
    push_word(mk(5'b00101), 1'b0);
    push_word(mk(5'b00011), 1'b0);
    idle(4, 1'b0);

    // Fill all 16 entries under stall (pointers wrap), 17th held off until space frees.
    for (int i = 0; i < DEPTH; i++) push_word(mk(5'($urandom_range(3, 31))), 1'b1);
    w17 = mk(5'b00110);
    repeat (3) drive(1'b1, w17, 1'b1, 1'b0);
    chk(q_count === 5'd16, "full_count", 64'(q_count), 64'd16);
    push_word(w17, 1'b0);
    idle(25, 1'b0);

    // Streaming op followed by a queued instruction.
    push_word(mk(5'b00001), 1'b0);
    push_word(mk(5'b00100), 1'b0);
    idle(15, 1'b0);

    // Opcode 00000 is dropped, 11111 issued normally.
    push_word(mk(5'b00000), 1'b0);
    push_word(mk(5'b11111), 1'b0);
    idle(4, 1'b0);

    // Flush while in HOLD with five entries waiting.
    push_word(mk(5'b00010), 1'b0);
    for (int i = 0; i < 5; i++) push_word(mk(5'(5 + i)), 1'b0);
    drive(1'b1, mk(5'b01000), 1'b0, 1'b1);
    #1;
    idle(1, 1'b0);
    push_word(mk(5'b00111), 1'b0);
    idle(5, 1'b0);

    // Random traffic including flushes and a reset in the middle.
    for (int i = 0; i < 700; i++) begin
      drive(($urandom_range(0, 1) == 1), mk(rand_op()), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 49) == 0));
      rst_n = !(i == 350 || i == 351);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Drain: worst case is every entry a streaming op.
    idle(DEPTH * (STREAM_LEN + 1) + 20, 1'b0);
    chk(exp_q.size() == 0 && q_count === '0, "drain", 64'(q_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
